// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (FETCH, WAIT, DRAIN)
//   fetch_pkt_t   : one fetched instruction together with its PC
//   BUBBLE_INSTR  : instruction word presented while no instruction is valid
//   PC_STEP       : sequential PC increment
//   pc_inc()      : sequential PC successor, modulo 2^32
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Wraps naturally at 2^32 because the result is 32 bits wide.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pending buffer that parks a fetched instruction while the
// output stage is stalled.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : drop the entry (highest priority after reset)
//   load_i       : capture pkt_i
//   consume_i    : entry has been moved to the outputs
//   pkt_i        : packet to capture
//   valid_o      : buffer holds an entry
//   pkt_o        : held packet
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       consume_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    // Next-state: clear beats load beats consume.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pkt_q   <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding requests
// to instruction memory and presents registered pc/instr/pc+4 to IF/ID.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   stall_i             : downstream hold, outputs freeze while high
//   redirect_i          : taken branch/jump, overrides stall
//   redirect_pc_i       : new fetch address when redirect_i is high
//   imem_req_o/addr_o   : fetch request and address (address = PC register)
//   imem_gnt_i          : request accepted
//   imem_rvalid_i/rdata : response, at least one cycle after grant
//   pc_o/instr_o/pc_add4_o/instr_valid_o : presented instruction (0 = bubble)
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o,
    output logic        instr_valid_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  out_add4_q, out_add4_d;

    logic         req_s;
    logic         deliver_s;
    logic [31:0]  fetched_pc_s;
    fetch_pkt_t   rsp_pkt_s;
    fetch_pkt_t   skid_pkt_s;
    logic         skid_valid_s;
    logic         skid_load_s;
    logic         skid_consume_s;
    logic         skid_clear_s;

    // A request is held back while an instruction is parked, which keeps
    // at most one instruction beyond the output register in flight.
    assign req_s = (state_q == FETCH) && !skid_valid_s;

    // pc_q has already advanced past the outstanding request while in WAIT,
    // and a redirect always leaves WAIT, so the fetched PC is pc_q - 4.
    assign fetched_pc_s = pc_q - PC_STEP;
    assign rsp_pkt_s    = '{pc: fetched_pc_s, instr: imem_rdata_i};

    fetch_skid_buf u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (skid_clear_s),
        .load_i    (skid_load_s),
        .consume_i (skid_consume_s),
        .pkt_i     (rsp_pkt_s),
        .valid_o   (skid_valid_s),
        .pkt_o     (skid_pkt_s)
    );

    // FSM next state, PC next value and output-register next values.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_instr_d    = out_instr_q;
        out_add4_d     = out_add4_q;
        deliver_s      = 1'b0;
        skid_load_s    = 1'b0;
        skid_consume_s = 1'b0;
        skid_clear_s   = 1'b0;

        case (state_q)
            FETCH: begin
                if (req_s && imem_gnt_i) begin
                    // A redirect cannot cancel an accepted request; its
                    // response must be drained instead.
                    if (redirect_i) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = WAIT;
                        pc_d    = pc_inc(pc_q);
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d   = FETCH;
                    deliver_s = !redirect_i;
                end else if (redirect_i) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                // The stale response ends the drain even if a further
                // redirect lands on the same cycle: nothing else is in flight.
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (redirect_i) begin
            pc_d         = redirect_pc_i;
            skid_clear_s = 1'b1;
            out_valid_d  = 1'b0;
            out_pc_d     = 32'h0000_0000;
            out_instr_d  = BUBBLE_INSTR;
            out_add4_d   = 32'h0000_0000;
        end else if (deliver_s) begin
            if (!out_valid_q || !stall_i) begin
                out_valid_d = 1'b1;
                out_pc_d    = fetched_pc_s;
                out_instr_d = imem_rdata_i;
                out_add4_d  = pc_q;
            end else begin
                skid_load_s = 1'b1;
            end
        end else if (!stall_i) begin
            if (skid_valid_s) begin
                skid_consume_s = 1'b1;
                out_valid_d    = 1'b1;
                out_pc_d       = skid_pkt_s.pc;
                out_instr_d    = skid_pkt_s.instr;
                out_add4_d     = pc_inc(skid_pkt_s.pc);
            end else begin
                out_valid_d = 1'b0;
                out_pc_d    = 32'h0000_0000;
                out_instr_d = BUBBLE_INSTR;
                out_add4_d  = 32'h0000_0000;
            end
        end else begin
            out_valid_d = out_valid_q;
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            out_add4_d  = out_add4_q;
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0000_0000;
            out_instr_q <= BUBBLE_INSTR;
            out_add4_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_add4_q  <= out_add4_d;
        end
    end

    assign imem_req_o    = req_s;
    assign imem_addr_o   = pc_q;
    assign pc_o          = out_pc_q;
    assign instr_o       = out_instr_q;
    assign pc_add4_o     = out_add4_q;
    assign instr_valid_o = out_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redir;
    logic [31:0] rdpc;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        req, valid;
    logic [31:0] addr, pc, instr, add4;

    logic        gnt_b, rvalid_b, req_b, valid_b;
    logic [31:0] rdata_b, addr_b, pc_b, instr_b, add4_b;

    if_fetch_unit u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(rdpc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .pc_o(pc), .instr_o(instr), .pc_add4_o(add4), .instr_valid_o(valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(req_b), .imem_addr_o(addr_b),
        .imem_gnt_i(gnt_b), .imem_rvalid_i(rvalid_b), .imem_rdata_i(rdata_b),
        .pc_o(pc_b), .instr_o(instr_b), .pc_add4_o(add4_b), .instr_valid_o(valid_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_present = 0;

    // Memory model: single outstanding, returns addr^KEY after lat cycles.
    logic        mem_rand = 1'b0;
    int          lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        req_seen = 1'b0, rst_seen = 1'b1;
    logic [31:0] addr_seen = 32'h0;

    always @(negedge clk) begin
        logic        b;
        int          c;
        logic [31:0] a;
        b = mem_busy;
        c = mem_cnt;
        a = mem_addr;
        if (rst_seen) begin
            b = 1'b0;
        end else begin
            if (rvalid) b = 1'b0;
            if (gnt && req_seen) begin
                b = 1'b1;
                a = addr_seen;
                c = (mem_rand ? int'($urandom_range(1, 3)) : lat) - 1;
            end
        end
        if (b && c == 0) begin
            rvalid <= 1'b1;
            rdata  <= a ^ KEY;
        end else begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            if (b) c = c - 1;
        end
        gnt       <= !b && (mem_rand ? ($urandom_range(0, 9) < 7) : 1'b1);
        mem_busy  <= b;
        mem_cnt   <= c;
        mem_addr  <= a;
        req_seen  <= req;
        addr_seen <= addr;
        rst_seen  <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model state: next PC that must be presented / requested.
    logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
    logic        p_rst, p_stall, p_redir, p_req, p_gnt, p_valid;
    logic [31:0] p_rdpc, p_addr, p_pc, p_instr, p_add4;

    // One clock: sample the cycle mid-way, then check the post-edge state.
    task automatic tick();
        @(negedge clk); #1;
        p_rst = rst; p_stall = stall; p_redir = redir; p_rdpc = rdpc;
        p_req = req; p_gnt = gnt; p_addr = addr;
        p_valid = valid; p_pc = pc; p_instr = instr; p_add4 = add4;
        @(posedge clk); #1;
        if (p_rst) begin
            exp_pc  = 32'h0;
            exp_req = 32'h0;
            chk1("m_rst_valid", valid, 1'b0);
        end else begin
            if (p_redir) begin
                exp_pc  = p_rdpc;
                exp_req = p_rdpc;
                chk1("m_redir_bubble", valid, 1'b0);
            end else if (p_req && p_gnt) begin
                exp_req = exp_req + 32'd4;
            end
            if (p_stall && !p_redir && p_valid) begin
                chk1("m_hold_valid", valid, 1'b1);
                chk("m_hold_pc", pc, p_pc);
                chk("m_hold_instr", instr, p_instr);
                chk("m_hold_add4", add4, p_add4);
            end
            if (p_req && !p_gnt && !p_redir) begin
                chk1("m_req_stable", req, 1'b1);
                chk("m_addr_stable", addr, p_addr);
            end
        end
        if (req) chk("m_req_addr", addr, exp_req);
        if (!valid) begin
            chk("m_bubble_pc", pc, 32'h0);
            chk("m_bubble_instr", instr, 32'h0);
            chk("m_bubble_add4", add4, 32'h0);
        end else if (!(p_valid && pc === p_pc)) begin
            chk("m_pres_pc", pc, exp_pc);
            chk("m_pres_instr", instr, exp_pc ^ KEY);
            chk("m_pres_add4", add4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_present++;
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int i = 0;
        while (!valid && i < bound) begin
            tick();
            i++;
        end
        chk1(tag, valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; rdpc = 32'h0;
        gnt_b = 1'b0; rvalid_b = 1'b0; rdata_b = 32'h0;
        tick();
        tick();

        // First cycle after reset.
        rst = 1'b0;
        gnt_b = 1'b1;
        chk1("rst_req", req, 1'b1);
        chk("rst_addr", addr, 32'h0);
        chk1("rst_valid", valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("b_rst_addr", addr_b, 32'hFFFF_FFFC);
        tick();
        gnt_b = 1'b0; rvalid_b = 1'b1; rdata_b = 32'h1234_5678;
        chk1("wait_noreq", req, 1'b0);
        tick();
        rvalid_b = 1'b0;
        chk("first_pc", pc, 32'h0);
        chk("first_instr", instr, 32'hA5A5_0000);
        chk("first_add4", add4, 32'd4);
        chk1("first_valid", valid, 1'b1);
        chk("addr_2", addr, 32'd4);
        chk("wrap_pc", pc_b, 32'hFFFF_FFFC);
        chk("wrap_add4", add4_b, 32'h0);
        chk1("wrap_req2", req_b, 1'b1);
        chk("wrap_addr2", addr_b, 32'h0);
        tick(); tick();
        chk("pc_4", pc, 32'd4);
        chk("addr_3", addr, 32'd8);
        tick(); tick();
        chk("pc_8", pc, 32'd8);
        chk("addr_4", addr, 32'd12);

        // Stall for 6 cycles while pc 8 is presented.
        stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("stall_pc", pc, 32'd8);
            chk1("stall_valid", valid, 1'b1);
            if (k >= 2) chk1("stall_noreq", req, 1'b0);
        end
        tick();
        stall = 1'b0;
        chk("stall_pc_last", pc, 32'd8);
        tick();
        chk("release_pc", pc, 32'd12);
        chk1("release_valid", valid, 1'b1);

        // Redirect while waiting on a slow response.
        lat = 3;
        tick();
        chk1("pre_redir_wait", req, 1'b0);
        redir = 1'b1; rdpc = 32'h100;
        tick();
        redir = 1'b0;
        chk1("redir_bubble", valid, 1'b0);
        chk1("drain_noreq", req, 1'b0);
        tick();
        chk1("drain_noreq2", req, 1'b0);
        tick();
        chk1("redir_req", req, 1'b1);
        chk("redir_addr", addr, 32'h100);
        lat = 1;
        wait_valid("redir_timeout", 10);
        chk("redir_pc", pc, 32'h100);

        // Redirect coinciding with rvalid while stalled.
        stall = 1'b1;
        tick();
        chk("rv_hold_pc", pc, 32'h100);
        redir = 1'b1; rdpc = 32'h200;
        tick();
        redir = 1'b0; stall = 1'b0;
        chk1("rv_redir_valid", valid, 1'b0);
        chk("rv_redir_pc", pc, 32'h0);
        chk1("rv_redir_req", req, 1'b1);
        chk("rv_redir_addr", addr, 32'h200);
        wait_valid("to200_timeout", 10);
        chk("pc_200", pc, 32'h200);

        // Reset while an instruction is parked.
        stall = 1'b1;
        tick();
        tick();
        chk1("pend_noreq", req, 1'b0);
        chk("pend_hold", pc, 32'h200);
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        chk1("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_add4", add4, 32'h0);
        chk1("mid_rst_req", req, 1'b1);
        chk("mid_rst_addr", addr, 32'h0);
        wait_valid("post_rst_timeout", 10);
        chk("post_rst_pc", pc, 32'h0);

        // Randomized traffic.
        mem_rand = 1'b1;
        n_present = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0)
                rdpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else
                rdpc = 32'($urandom_range(0, 1023)) * 32'd4;
            tick();
        end
        stall = 1'b0; redir = 1'b0; rst = 1'b0;
        tick();
        chk1("progress", n_present > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
